// File: rtl/dmem_dump_sequencer.sv
// Paces the CPU with a clock enable until it reports done, then freezes it and
// cycles a fixed window of data memory onto the display, one word per dwell period or step.
module dmem_dump_sequencer #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned WORD_COUNT = 16,
  parameter int unsigned DWELL      = 50000000,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_done,
  input  logic              step,
  output logic              cpu_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       disp_data,
  output logic              disp_valid,
  output logic [7:0]        index,
  output logic [1:0]        state
);

  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [PH_W-1:0] PHASE_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [7:0]      INDEX_LAST = 8'(WORD_COUNT - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [7:0]        index_q, index_d;
  logic              cpu_en_d;
  logic              mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [31:0]       disp_data_d;
  logic              disp_valid_d;
  logic              advance;

  // Timeout and step landing together still count as one advance.
  assign advance = (state_q == S_SHOW) && ((dwell_q == DWELL_LAST) || step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:  if (cpu_done) state_d = S_READ;
      S_READ: state_d = S_WAIT;
      S_WAIT: state_d = S_SHOW;
      S_SHOW: if (advance) state_d = S_READ;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    phase_d      = phase_q;
    dwell_d      = dwell_q;
    index_d      = index_q;
    cpu_en_d     = 1'b0;
    mem_rd_d     = 1'b0;
    mem_addr_d   = mem_addr;
    disp_data_d  = disp_data;
    disp_valid_d = disp_valid;
    case (state_q)
      S_RUN: begin
        phase_d  = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        cpu_en_d = (phase_q == PHASE_LAST) && !cpu_done;
        if (cpu_done) index_d = 8'd0;
      end
      S_WAIT: begin
        // Read data returns one cycle after the strobe, i.e. during this state.
        disp_data_d  = mem_rdata;
        disp_valid_d = 1'b1;
        dwell_d      = '0;
      end
      S_SHOW: begin
        dwell_d = dwell_q + 1'b1;
        if (advance) index_d = (index_q == INDEX_LAST) ? 8'd0 : index_q + 8'd1;
      end
      default: ;
    endcase
    if (state_d == S_READ) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = ADDR_W'(BASE_ADDR + 32'(index_d));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      dwell_q    <= '0;
      index_q    <= 8'd0;
      cpu_en     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      disp_data  <= 32'd0;
      disp_valid <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      dwell_q    <= dwell_d;
      index_q    <= index_d;
      cpu_en     <= cpu_en_d;
      mem_rd     <= mem_rd_d;
      mem_addr   <= mem_addr_d;
      disp_data  <= disp_data_d;
      disp_valid <= disp_valid_d;
    end
  end

  assign index = index_q;
  assign state = state_q;

endmodule

// File: tb/tb_dmem_dump_sequencer.sv
// Directed bench: CLK_DIV=2, DWELL=4, WORD_COUNT=3, BASE_ADDR=8 against a one-cycle-latency dmem model.
module tb_dmem_dump_sequencer;

  logic        clk;
  logic        rst;
  logic        cpu_done;
  logic        step;
  logic        cpu_en;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic [7:0]  index;
  logic [1:0]  state;

  logic [31:0] mem [0:1023];
  int          checks;
  int          errors;
  int          cyc_n;

  dmem_dump_sequencer #(
    .ADDR_W(10), .BASE_ADDR(8), .WORD_COUNT(3), .DWELL(4), .CLK_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .cpu_done(cpu_done), .step(step),
    .cpu_en(cpu_en), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .disp_data(disp_data), .disp_valid(disp_valid), .index(index), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic run_to(input int n);
    while (cyc_n < n) cyc();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_cpu_en"}, 32'(cpu_en), 32'd0);
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_disp_data"}, disp_data, 32'd0);
    check({tag, "_disp_valid"}, 32'(disp_valid), 32'd0);
    check({tag, "_index"}, 32'(index), 32'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc_n    = 0;
    rst      = 1'b1;
    cpu_done = 1'b0;
    step     = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hdead0000 | 32'(i);
    mem[8]  = 32'h11111111;
    mem[9]  = 32'h22222222;
    mem[10] = 32'h33333333;

    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;

    // Pacing: enable on every even cycle after release.
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check("run_cpu_en", 32'(cpu_en), 32'((k % 2) == 0));
    end
    check("run_mem_rd", 32'(mem_rd), 32'd0);
    check("run_disp_valid", 32'(disp_valid), 32'd0);
    check("run_state", 32'(state), 32'd0);

    cpu_done = 1'b1;
    cyc();  // 11: READ
    check("rd0_state", 32'(state), 32'd1);
    check("rd0_mem_rd", 32'(mem_rd), 32'd1);
    check("rd0_addr", 32'(mem_addr), 32'd8);
    check("rd0_cpu_en", 32'(cpu_en), 32'd0);
    check("rd0_index", 32'(index), 32'd0);
    cyc();  // 12: WAIT
    cpu_done = 1'b0;
    check("wait0_state", 32'(state), 32'd2);
    check("wait0_mem_rd", 32'(mem_rd), 32'd0);
    check("wait0_disp_valid", 32'(disp_valid), 32'd0);
    cyc();  // 13: SHOW
    check("show0_state", 32'(state), 32'd3);
    check("show0_data", disp_data, 32'h11111111);
    check("show0_valid", 32'(disp_valid), 32'd1);
    check("show0_cpu_en", 32'(cpu_en), 32'd0);

    // Free-running walk, 6 cycles per word.
    run_to(16); check("dwell_last_state", 32'(state), 32'd3);
    run_to(17);
    check("rd1_state", 32'(state), 32'd1);
    check("rd1_mem_rd", 32'(mem_rd), 32'd1);
    check("rd1_addr", 32'(mem_addr), 32'd9);
    check("rd1_index", 32'(index), 32'd1);
    check("rd1_hold_data", disp_data, 32'h11111111);
    run_to(18); check("wait1_hold_data", disp_data, 32'h11111111);
    run_to(19); check("show1_data", disp_data, 32'h22222222);
    run_to(23);
    check("rd2_addr", 32'(mem_addr), 32'd10);
    check("rd2_index", 32'(index), 32'd2);
    check("rd2_mem_rd", 32'(mem_rd), 32'd1);
    run_to(25); check("show2_data", disp_data, 32'h33333333);
    run_to(29);
    check("wrap_addr", 32'(mem_addr), 32'd8);
    check("wrap_index", 32'(index), 32'd0);
    run_to(31);
    check("wrap_data", disp_data, 32'h11111111);
    check("wrap_state", 32'(state), 32'd3);
    check("wrap_cpu_en", 32'(cpu_en), 32'd0);
    check("wrap_valid", 32'(disp_valid), 32'd1);

    // Early step on second SHOW cycle.
    run_to(32);
    step = 1'b1; cyc(); step = 1'b0;  // 33
    check("step_state", 32'(state), 32'd1);
    check("step_addr", 32'(mem_addr), 32'd9);
    check("step_index", 32'(index), 32'd1);
    run_to(35); check("step_data", disp_data, 32'h22222222);
    run_to(38); check("step_dwell_restart", 32'(state), 32'd3);
    run_to(39);
    check("rd_after_step_state", 32'(state), 32'd1);
    check("rd_after_step_addr", 32'(mem_addr), 32'd10);
    // Step during READ must be dropped.
    step = 1'b1; cyc(); step = 1'b0;  // 40
    check("read_step_wait", 32'(state), 32'd2);
    run_to(44);
    check("read_step_ignored_state", 32'(state), 32'd3);
    check("read_step_ignored_index", 32'(index), 32'd2);
    run_to(45);
    check("rd_wrap2_state", 32'(state), 32'd1);
    check("rd_wrap2_addr", 32'(mem_addr), 32'd8);
    check("rd_wrap2_index", 32'(index), 32'd0);
    run_to(47); check("show_wrap2_data", disp_data, 32'h11111111);

    // Step coincident with the dwell timeout.
    run_to(50);
    check("coinc_pre_state", 32'(state), 32'd3);
    step = 1'b1; cyc(); step = 1'b0;  // 51
    check("coinc_state", 32'(state), 32'd1);
    check("coinc_addr", 32'(mem_addr), 32'd9);
    check("coinc_index", 32'(index), 32'd1);
    cyc();  // 52
    check("coinc_wait", 32'(state), 32'd2);
    cyc();  // 53
    check("coinc_show", 32'(state), 32'd3);
    check("coinc_data", disp_data, 32'h22222222);
    check("coinc_index_once", 32'(index), 32'd1);

    // Asynchronous reset in the middle of SHOW.
    run_to(54);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (3) cyc();
    check("midrst_hold_state", 32'(state), 32'd0);
    check("midrst_hold_valid", 32'(disp_valid), 32'd0);
    rst = 1'b0;
    cyc_n = 0;
    cyc();
    check("rerun_c1_cpu_en", 32'(cpu_en), 32'd0);
    check("rerun_c1_state", 32'(state), 32'd0);
    check("rerun_c1_valid", 32'(disp_valid), 32'd0);
    cyc();
    check("rerun_c2_cpu_en", 32'(cpu_en), 32'd1);
    cpu_done = 1'b1;
    cyc();
    check("rerun_rd_state", 32'(state), 32'd1);
    check("rerun_rd_addr", 32'(mem_addr), 32'd8);
    check("rerun_rd_mem_rd", 32'(mem_rd), 32'd1);
    check("rerun_rd_cpu_en", 32'(cpu_en), 32'd0);
    cyc();
    cyc();
    check("rerun_show_data", disp_data, 32'h11111111);
    check("rerun_show_valid", 32'(disp_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_dump_sequencer.md
Name: dmem_dump_sequencer

Overview:
Run/dump controller that sits between the CPU core, its data memory read port and the 7-segment display driver. After reset it paces the CPU with a clock enable. Once the CPU asserts done, it freezes the CPU and walks a fixed window of data memory. Each word in the window is presented to the display for a dwell time, or until the user steps forward, and the walk wraps around forever.

Parameters:
ADDR_W, 10, word-address width of the dmem read port
BASE_ADDR, 0, first word address of the dump window
WORD_COUNT, 16, number of words in the window (1..256)
DWELL, 50000000, clk cycles each word is held on the display (>=1)
CLK_DIV, 2, CPU enable asserted 1 cycle in every CLK_DIV cycles (>=1; 1 = always enabled)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
cpu_done  in  1  CPU finished flag (level; may drop later and is ignored)
step  in  1  one-cycle pulse, already synchronized/debounced; advance to next word now
cpu_en  out  1  CPU clock enable
mem_rd  out  1  dmem read strobe
mem_addr  out  ADDR_W  dmem word address
mem_rdata  in  32  dmem read data, valid on the cycle after mem_rd
disp_data  out  32  word to display
disp_valid  out  1  display chip-select; high once the first word is captured
index  out  8  current offset within the window
state  out  2  RUN=0, READ=1, WAIT=2, SHOW=3 (debug)

Behaviour:
- Reset values (async): state=RUN, cpu_en=0, mem_rd=0, mem_addr=0, disp_data=0, disp_valid=0, index=0, phase counter=0, dwell counter=0.
- All outputs are registered.
- RUN:
  - Phase counter counts 0..CLK_DIV-1 and wraps.
  - cpu_en=1 exactly when the registered phase equals CLK_DIV-1.
  - First cpu_en pulse appears CLK_DIV cycles after reset release.
  - On a cycle where cpu_done=1: next state READ, cpu_en forced 0 from the next cycle, index=0. The CPU gets no further enables until reset.
  - If cpu_done=1 on the same edge the phase reaches CLK_DIV-1, done wins and no enable is issued.
- READ (1 cycle):
  - mem_rd=1, mem_addr=BASE_ADDR+index, truncated to ADDR_W, wrapping modulo 2^ADDR_W.
  - Next state WAIT.
- WAIT (1 cycle):
  - mem_rd=0.
  - At the end of the cycle, disp_data<=mem_rdata, disp_valid<=1, dwell counter<=0.
  - Next state SHOW.
- SHOW:
  - Dwell counter increments each cycle.
  - When the counter reaches DWELL-1, or step=1: index<=(index==WORD_COUNT-1)?0:index+1, next state READ.
  - Simultaneous timeout and step produce a single advance.
  - step in RUN, READ or WAIT is ignored (not queued).
- Display update latency: 2 cycles from leaving SHOW to the new disp_data.
- Word period without step: DWELL+2 cycles.
- disp_data holds the previous word during READ/WAIT, so the display never blanks.
- disp_valid never returns to 0 except on reset.
- cpu_done is not used outside RUN; deassertion during the dump has no effect.
- Reset mid-dump: immediate return to RUN, display blanked (disp_valid=0), CPU restarts pacing.
- Counter widths: dwell counter is ceil(log2(DWELL)) bits, minimum 1. Phase counter is ceil(log2(CLK_DIV)) bits, minimum 1.

Test Plan:
All scenarios use CLK_DIV=2, DWELL=4, WORD_COUNT=3, BASE_ADDR=8, with a dmem model holding mem[8]=0x11111111, mem[9]=0x22222222, mem[10]=0x33333333.

1. Release reset, cpu_done=0 for 10 cycles -> cpu_en = 0,1,0,1,... with the first 1 on cycle 2; mem_rd=0; disp_valid=0.
2. Assert cpu_done at cycle 10 -> cpu_en stays 0 afterwards; mem_rd=1 with mem_addr=8 on cycle 11; disp_data=0x11111111 and disp_valid=1 from cycle 13.
3. No step -> displayed word advances every 6 cycles: 0x22222222 at addr 9, then 0x33333333 at addr 10, then wraps to 0x11111111 (index 2->0).
4. Pulse step on the 2nd SHOW cycle of word 0 -> mem_rd at addr 9 on the next cycle, 0x22222222 two cycles later; dwell counter restarts. Step pulsed during READ -> no extra advance.
5. step coincident with the dwell timeout -> index advances by exactly 1.
6. Assert rst mid-SHOW, hold 3 cycles, release -> all outputs at reset values immediately; RUN pacing resumes with cpu_en high 2 cycles after release; cpu_done held high re-enters READ at addr 8.
